// File: rtl/regfile_writeback_ctrl.sv
// Register file write-side initiator: arbitrates ALU/LSU results onto one write port, tracks in-flight loads.
// Latency: accepted write appears on rf_* one cycle after acceptance; busy bit clears at the following edge.
// Backpressure: LSU is always accepted; ALU is stalled whenever the LSU presents a result; issue stalls on load hazards.
module regfile_writeback_ctrl #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int MAXLD = 8
) (
  input  logic            clk,
  input  logic            reset,
  // issue side
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_is_load,
  output logic            iss_ready,
  // ALU result
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  // LSU load result
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  // register file write port
  output logic            rf_reg_write,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  // scoreboard visibility
  output logic [NREG-1:0] busy_mask,
  output logic [3:0]      pending_loads
);

  localparam logic [3:0] MAX_CNT = 4'(MAXLD);

  // Scoreboard state: one busy bit per register, bit 0 never set.
  logic [NREG-1:0] busy;
  logic [3:0]      pend_cnt;
  // Set when the write currently on rf_* came from the LSU, so its commit
  // retires a load from the scoreboard (including loads aimed at x0).
  logic            lsu_commit;

  // Arbitration results
  logic            lsu_fire;
  logic            alu_fire;
  logic            wr_fire;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;

  // Issue / scoreboard next-state
  logic            issue_ok;
  logic            ld_issue;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_nxt;
  logic [3:0]      pend_nxt;

  // Fixed-priority arbitration: the load is the older instruction, so it always wins.
  always_comb begin
    lsu_ready = 1'b1;
    alu_ready = !lsu_valid;
    lsu_fire  = lsu_valid;
    alu_fire  = alu_valid && !lsu_valid;
    wr_fire   = lsu_fire || alu_fire;
    wr_rd     = lsu_fire ? lsu_rd   : alu_rd;
    wr_data   = lsu_fire ? lsu_data : alu_data;
  end

  // Hazard check: stall on RAW/WAW against any pending load, or when the load tracker is full.
  // x0 never stalls because its busy bit is held at zero.
  always_comb begin
    issue_ok  = !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]) &&
                !(iss_is_load && (pend_cnt == MAX_CNT));
    iss_ready = issue_ok;
    ld_issue  = iss_valid && issue_ok && iss_is_load;
  end

  // Scoreboard next state: clear on LSU commit, set on load issue; set wins on collision.
  // Every issued load counts toward pending_loads, even one aimed at x0, so that
  // its commit has something to retire.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ld_issue && (iss_rd != '0)) begin
      set_mask[iss_rd] = 1'b1;
    end
    if (lsu_commit) begin
      clr_mask[rf_rd] = 1'b1;
    end
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;

    pend_nxt = pend_cnt;
    case ({ld_issue, lsu_commit})
      2'b10: begin
        if (pend_cnt != MAX_CNT) begin
          pend_nxt = pend_cnt + 4'd1;
        end
      end
      2'b01: begin
        if (pend_cnt != 4'd0) begin
          pend_nxt = pend_cnt - 4'd1;
        end
      end
      default: begin
        pend_nxt = pend_cnt;
      end
    endcase
  end

  // Registered write port: one-cycle pulse per accepted write, none for x0; address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_reg_write  <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      lsu_commit    <= 1'b0;
    end else begin
      rf_reg_write <= wr_fire && (wr_rd != '0);
      lsu_commit   <= lsu_fire;
      if (wr_fire) begin
        rf_rd         <= wr_rd;
        rf_write_data <= wr_data;
      end
    end
  end

  // Scoreboard registers; reset drops every outstanding load.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= 4'd0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_nxt;
    end
  end

  assign busy_mask     = busy;
  assign pending_loads = pend_cnt;

  // A load commit with nothing pending means the LSU returned a load that was never issued.
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    lsu_commit |-> (pend_cnt != 4'd0));

  // A load result for a register nobody is waiting on is a stray LSU response.
  a_lsu_rd_busy : assert property (@(posedge clk) disable iff (reset)
    (lsu_valid && (lsu_rd != '0)) |-> busy[lsu_rd]);

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
module tb_regfile_writeback_ctrl;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int MAXLD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            iss_valid, iss_is_load, iss_ready;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_reg_write;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [NREG-1:0] busy_mask;
  logic [3:0]      pending_loads;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .MAXLD(MAXLD)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_is_load(iss_is_load), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .busy_mask(busy_mask), .pending_loads(pending_loads)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: list of loads issued but not yet returned, plus the one
  // returned load whose commit retires it at the next edge.
  logic [AW-1:0] waiting[$];
  bit            ret_vld = 1'b0;
  logic [AW-1:0] ret_rd  = '0;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [XLEN-1:0] rf_model [NREG];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    if (ret_vld && ret_rd == r) return 1'b1;
    foreach (waiting[i]) if (waiting[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pend();
    return waiting.size() + (ret_vld ? 1 : 0);
  endfunction

  function automatic bit m_ready(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input logic [AW-1:0] d, input bit ld);
    if (m_busy(s1) || m_busy(s2) || m_busy(d)) return 1'b0;
    if (ld && m_pend() >= MAXLD) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NREG-1:0] m_mask();
    logic [NREG-1:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = m_busy(AW'(r));
    return m;
  endfunction

  // Model update at each edge: predict writes, retire last returned load, record returns and issues.
  always @(posedge clk) begin
    bit rdy;
    int idx;
    cyc++;
    if (reset) begin
      waiting.delete();
      ret_vld = 1'b0;
      exp_q.delete();
    end else begin
      rdy = m_ready(iss_rs1, iss_rs2, iss_rd, iss_is_load);
      if (lsu_valid) begin
        if (lsu_rd != '0) exp_q.push_back('{cyc, lsu_rd, lsu_data});
      end else if (alu_valid) begin
        if (alu_rd != '0) exp_q.push_back('{cyc, alu_rd, alu_data});
      end
      ret_vld = 1'b0;
      if (lsu_valid) begin
        idx = -1;
        foreach (waiting[i]) if (idx < 0 && waiting[i] == lsu_rd) idx = i;
        if (idx >= 0) waiting.delete(idx);
        ret_vld = 1'b1;
        ret_rd  = lsu_rd;
      end
      if (iss_valid && rdy && iss_is_load) waiting.push_back(iss_rd);
    end
  end

  // Monitor: compares DUT outputs with the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("lsu_ready", 64'(lsu_ready), 64'd1);
      check("alu_ready", 64'(alu_ready), 64'(!lsu_valid));
      check("iss_ready", 64'(iss_ready), 64'(m_ready(iss_rs1, iss_rs2, iss_rd, iss_is_load)));
      check("busy_mask", 64'(busy_mask), 64'(m_mask()));
      check("pending_loads", 64'(pending_loads), 64'(m_pend()));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("wr_pulse", 64'(rf_reg_write), 64'd1);
        check("wr_rd", 64'(rf_rd), 64'(exp_q[0].rd));
        check("wr_data", 64'(rf_write_data), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        check("wr_idle", 64'(rf_reg_write), 64'd0);
      end
      if (rf_reg_write) rf_model[rf_rd] = rf_write_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_is_load = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d, input bit ld);
    iss_valid = 1; iss_rs1 = s1; iss_rs2 = s2; iss_rd = d; iss_is_load = ld;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) rf_model[r] = '0;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_rf_rd", 64'(rf_rd), 64'd0);
    check("rst_rf_data", 64'(rf_write_data), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    tick();

    // ALU write to x5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    tick();
    check("rf_x5", 64'(rf_model[5]), 64'hDEADBEEF);

    // RAW stall on a pending load to x7
    issue(0, 0, 7, 1);
    tick();
    issue(7, 0, 1, 0);
    #1 check("raw_stall", 64'(iss_ready), 64'd0);
    tick();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    tick();
    lsu_valid = 0;
    #1 check("raw_stall_commit", 64'(iss_ready), 64'd0);
    tick();
    check("raw_release", 64'(iss_ready), 64'd1);
    check("rf_x7", 64'(rf_model[7]), 64'h1234);
    iss_valid = 0;
    tick();

    // ALU and LSU collide; LSU first, ALU held
    issue(0, 0, 4, 1);
    tick();
    iss_valid = 0;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
    #1 check("collide_alu_rdy", 64'(alu_ready), 64'd0);
    tick();
    lsu_valid = 0;
    #1 check("held_alu_rdy", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 0;
    tick();
    check("rf_x3", 64'(rf_model[3]), 64'h3333);
    check("rf_x4", 64'(rf_model[4]), 64'h4444);

    // x0 writes: ALU and load
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    tick();
    alu_valid = 0;
    issue(0, 0, 0, 1);
    tick();
    iss_valid = 0;
    check("x0_load_pend", 64'(pending_loads), 64'd1);
    check("x0_load_busy", 64'(busy_mask), 64'd0);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h5555;
    tick();
    lsu_valid = 0;
    tick();
    check("x0_load_done", 64'(pending_loads), 64'd0);

    // Fill the load tracker, ninth load stalls
    for (int r = 1; r <= MAXLD; r++) begin
      issue(0, 0, AW'(r), 1);
      tick();
    end
    issue(0, 0, 9, 1);
    #1 check("full_pend", 64'(pending_loads), 64'(MAXLD));
    check("full_stall", 64'(iss_ready), 64'd0);
    iss_valid = 0;
    for (int r = 1; r <= MAXLD; r++) begin
      lsu_valid = 1; lsu_rd = AW'(r); lsu_data = $urandom;
      tick();
    end
    lsu_valid = 0;
    tick();

    // Reset with loads outstanding
    issue(0, 0, 4, 1); tick();
    issue(0, 0, 5, 1); tick();
    iss_valid = 0;
    check("pre_rst_busy", 64'(busy_mask), 64'h30);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_busy", 64'(busy_mask), 64'd0);
    check("mid_rst_pend", 64'(pending_loads), 64'd0);
    check("mid_rst_wr", 64'(rf_reg_write), 64'd0);

    // Randomized traffic with one reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
      end
      if (!alu_valid && $urandom_range(0, 2) == 0) begin
        alu_valid = 1; alu_rd = AW'($urandom_range(0, 9)); alu_data = $urandom;
      end
      lsu_valid = 0;
      if (waiting.size() > 0 && $urandom_range(0, 2) == 0) begin
        lsu_valid = 1;
        lsu_rd    = waiting[$urandom_range(0, waiting.size() - 1)];
        lsu_data  = $urandom;
      end
      iss_valid   = $urandom_range(0, 1);
      iss_rs1     = AW'($urandom_range(0, 9));
      iss_rs2     = AW'($urandom_range(0, 9));
      iss_rd      = AW'($urandom_range(0, 9));
      iss_is_load = $urandom_range(0, 1);
      tick();
      if (alu_valid && !lsu_valid) alu_valid = 0;
    end

    // Drain remaining loads
    iss_valid = 0;
    for (int n = 0; n < 40 && (waiting.size() > 0 || alu_valid); n++) begin
      lsu_valid = 0;
      if (waiting.size() > 0) begin
        lsu_valid = 1; lsu_rd = waiting[0]; lsu_data = $urandom;
      end
      tick();
      if (alu_valid && !lsu_valid) alu_valid = 0;
    end
    idle_inputs();
    tick(); tick();
    check("end_pend", 64'(pending_loads), 64'd0);
    check("end_busy", 64'(busy_mask), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
